// File: rtl/packet_scheduler_if.sv
// Slot request / packet decision bus between assembler and scheduler.
// The assembler is the master: it opens slots and consumes decisions.
interface packet_scheduler_if;
    logic       packet_slot;
    logic       packet_valid;
    logic [7:0] packet_type;
    logic       audio_pop;

    modport master (
        output packet_slot,
        input  packet_valid,
        input  packet_type,
        input  audio_pop
    );

    modport slave (
        input  packet_slot,
        output packet_valid,
        output packet_type,
        output audio_pop
    );
endinterface

// File: rtl/packet_scheduler.sv
// Per-slot HDMI data-island packet arbiter in the pixel clock domain.
// Priority: ACR, overdue InfoFrames, audio, then AVI/AIF/SPD, else null.
module packet_scheduler #(
    parameter int AUDIO_SAMPLES_PER_PACKET = 4,
    parameter int AUDIO_LEVEL_WIDTH        = 5,
    parameter int INFOFRAME_MAX_WAIT       = 8
) (
    input  logic                         clk_pixel,
    input  logic                         reset,
    input  logic                         clk_audio_counter_wrap,
    input  logic                         frame_start,
    input  logic [AUDIO_LEVEL_WIDTH-1:0] audio_fifo_level,
    packet_scheduler_if.slave            pkt,
    output logic                         acr_overrun
);

    localparam int CW = $clog2(INFOFRAME_MAX_WAIT + 1);
    localparam logic [CW-1:0] MAXW = CW'(INFOFRAME_MAX_WAIT);
    localparam logic [AUDIO_LEVEL_WIDTH-1:0] AUD_MIN =
        AUDIO_LEVEL_WIDTH'(AUDIO_SAMPLES_PER_PACKET);

    localparam logic [7:0] T_NULL = 8'h00;
    localparam logic [7:0] T_ACR  = 8'h01;
    localparam logic [7:0] T_AUD  = 8'h02;
    localparam logic [7:0] T_AVI  = 8'h82;
    localparam logic [7:0] T_AIF  = 8'h84;
    localparam logic [7:0] T_SPD  = 8'h83;

    logic          wrap_q;
    logic          acr_pend;
    logic [2:0]    if_pend;
    logic [CW-1:0] if_cnt [3];

    logic       acr_evt;
    logic       acr_req;
    logic       aud_ok;
    logic [2:0] urgent;
    logic [7:0] sel_type;
    logic       take_acr;
    logic       take_aud;
    logic [2:0] take_if;

    always_comb begin
        acr_evt  = clk_audio_counter_wrap != wrap_q;
        acr_req  = acr_pend | acr_evt;
        aud_ok   = audio_fifo_level >= AUD_MIN;
        for (int i = 0; i < 3; i++)
            urgent[i] = if_pend[i] && (if_cnt[i] == MAXW);
        sel_type = T_NULL;
        take_acr = 1'b0;
        take_aud = 1'b0;
        take_if  = 3'b000;
        // InfoFrame index: 0 = AVI, 1 = AIF, 2 = SPD
        if (acr_req) begin
            take_acr = 1'b1;
            sel_type = T_ACR;
        end else if (urgent[0]) begin
            take_if  = 3'b001;
            sel_type = T_AVI;
        end else if (urgent[1]) begin
            take_if  = 3'b010;
            sel_type = T_AIF;
        end else if (urgent[2]) begin
            take_if  = 3'b100;
            sel_type = T_SPD;
        end else if (aud_ok) begin
            take_aud = 1'b1;
            sel_type = T_AUD;
        end else if (if_pend[0]) begin
            take_if  = 3'b001;
            sel_type = T_AVI;
        end else if (if_pend[1]) begin
            take_if  = 3'b010;
            sel_type = T_AIF;
        end else if (if_pend[2]) begin
            take_if  = 3'b100;
            sel_type = T_SPD;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            wrap_q           <= clk_audio_counter_wrap;
            acr_pend         <= 1'b0;
            acr_overrun      <= 1'b0;
            if_pend          <= 3'b000;
            for (int i = 0; i < 3; i++)
                if_cnt[i] <= '0;
            pkt.packet_valid <= 1'b0;
            pkt.packet_type  <= T_NULL;
            pkt.audio_pop    <= 1'b0;
        end else begin
            wrap_q           <= clk_audio_counter_wrap;
            pkt.packet_valid <= pkt.packet_slot;
            pkt.audio_pop    <= pkt.packet_slot & take_aud;
            if (pkt.packet_slot)
                pkt.packet_type <= sel_type;

            // A same-cycle event either refills a consumed flag or is itself consumed
            if (pkt.packet_slot && take_acr)
                acr_pend <= acr_pend & acr_evt;
            else
                acr_pend <= acr_req;

            if (acr_evt && acr_pend && !(pkt.packet_slot && take_acr))
                acr_overrun <= 1'b1;

            for (int i = 0; i < 3; i++) begin
                if (frame_start) begin
                    if_pend[i] <= 1'b1;
                    if_cnt[i]  <= '0;
                end else if (pkt.packet_slot) begin
                    if (take_if[i]) begin
                        if_pend[i] <= 1'b0;
                        if_cnt[i]  <= '0;
                    end else if (if_pend[i] && if_cnt[i] != MAXW) begin
                        if_cnt[i] <= if_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed bench for packet_scheduler: priority, latency, overrun, reset.
// Inputs change on the falling edge, outputs are read on the falling edge.
module tb_packet_scheduler;

    logic       clk_pixel = 1'b0;
    logic       reset = 1'b1;
    logic       wrap = 1'b1;
    logic       frame_start = 1'b0;
    logic [4:0] level = 5'd0;
    logic       acr_overrun;

    int errors = 0;
    int checks = 0;

    packet_scheduler_if bus ();

    packet_scheduler #(
        .AUDIO_SAMPLES_PER_PACKET(4),
        .AUDIO_LEVEL_WIDTH(5),
        .INFOFRAME_MAX_WAIT(8)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset(reset),
        .clk_audio_counter_wrap(wrap),
        .frame_start(frame_start),
        .audio_fifo_level(level),
        .pkt(bus.slave),
        .acr_overrun(acr_overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic do_reset();
        @(negedge clk_pixel);
        reset = 1'b1;
        repeat (2) @(negedge clk_pixel);
        reset = 1'b0;
    endtask

    task automatic toggle_wrap();
        @(negedge clk_pixel);
        wrap = ~wrap;
    endtask

    task automatic pulse_frame();
        @(negedge clk_pixel);
        frame_start = 1'b1;
        @(negedge clk_pixel);
        frame_start = 1'b0;
    endtask

    task automatic do_slot(input logic tog, output logic v,
                           output logic [7:0] t, output logic p);
        @(negedge clk_pixel);
        bus.packet_slot = 1'b1;
        if (tog) wrap = ~wrap;
        @(negedge clk_pixel);
        bus.packet_slot = 1'b0;
        v = bus.packet_valid;
        t = bus.packet_type;
        p = bus.audio_pop;
    endtask

    task automatic test_reset();
        logic v, p;
        logic [7:0] t;
        wrap = 1'b1;
        do_reset();
        checks++;
        if (bus.packet_valid !== 1'b0 || bus.packet_type !== 8'h00 ||
            bus.audio_pop !== 1'b0 || acr_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: v=%b t=%h p=%b ov=%b want 0 00 0 0",
                     bus.packet_valid, bus.packet_type, bus.audio_pop,
                     acr_overrun);
        end
        do_slot(1'b0, v, t, p);
        checks++;
        if (v !== 1'b1 || t !== 8'h00 || acr_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_slot: v=%b t=%h ov=%b want 1 00 0",
                     v, t, acr_overrun);
        end
        @(negedge clk_pixel);
        checks++;
        if (bus.packet_valid !== 1'b0 || bus.packet_type !== 8'h00) begin
            errors++;
            $display("FAIL valid_pulse: v=%b t=%h want 0 00 (held)",
                     bus.packet_valid, bus.packet_type);
        end
    endtask

    task automatic test_acr_audio();
        logic v, p;
        logic [7:0] t;
        level = 5'd6;
        toggle_wrap();
        do_slot(1'b0, v, t, p);
        checks++;
        if (v !== 1'b1 || t !== 8'h01 || p !== 1'b0) begin
            errors++;
            $display("FAIL acr_first: v=%b t=%h p=%b want 1 01 0", v, t, p);
        end
        do_slot(1'b0, v, t, p);
        checks++;
        if (v !== 1'b1 || t !== 8'h02 || p !== 1'b1) begin
            errors++;
            $display("FAIL audio_after_acr: v=%b t=%h p=%b want 1 02 1",
                     v, t, p);
        end
    endtask

    task automatic test_audio_threshold();
        logic v, p;
        logic [7:0] t;
        do_reset();
        level = 5'd3;
        do_slot(1'b0, v, t, p);
        checks++;
        if (t !== 8'h00 || p !== 1'b0) begin
            errors++;
            $display("FAIL audio_below: t=%h p=%b want 00 0", t, p);
        end
        level = 5'd4;
        do_slot(1'b0, v, t, p);
        checks++;
        if (t !== 8'h02 || p !== 1'b1) begin
            errors++;
            $display("FAIL audio_at_min: t=%h p=%b want 02 1", t, p);
        end
    endtask

    task automatic test_overrun();
        logic v, p;
        logic [7:0] t;
        do_reset();
        level = 5'd6;
        toggle_wrap();
        toggle_wrap();
        @(negedge clk_pixel);
        checks++;
        if (acr_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: ov=%b want 1", acr_overrun);
        end
        do_slot(1'b0, v, t, p);
        checks++;
        if (t !== 8'h01) begin
            errors++;
            $display("FAIL overrun_acr: t=%h want 01", t);
        end
        do_slot(1'b0, v, t, p);
        checks++;
        if (t !== 8'h02 || acr_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: t=%h ov=%b want 02 1",
                     t, acr_overrun);
        end
    endtask

    task automatic test_infoframe_promotion();
        logic v, p;
        logic [7:0] t;
        logic [7:0] exp;
        do_reset();
        level = 5'd16;
        pulse_frame();
        for (int i = 1; i <= 12; i++) begin
            do_slot(1'b0, v, t, p);
            case (i)
                9:       exp = 8'h82;
                10:      exp = 8'h84;
                11:      exp = 8'h83;
                default: exp = 8'h02;
            endcase
            checks++;
            if (t !== exp || p !== (exp == 8'h02)) begin
                errors++;
                $display("FAIL promote_slot%0d: t=%h p=%b want %h %b",
                         i, t, p, exp, exp == 8'h02);
            end
        end
    endtask

    task automatic test_infoframe_idle();
        logic v, p;
        logic [7:0] t;
        logic [7:0] exp [4];
        exp[0] = 8'h82;
        exp[1] = 8'h84;
        exp[2] = 8'h83;
        exp[3] = 8'h00;
        do_reset();
        level = 5'd0;
        pulse_frame();
        for (int i = 0; i < 4; i++) begin
            do_slot(1'b0, v, t, p);
            checks++;
            if (t !== exp[i] || p !== 1'b0) begin
                errors++;
                $display("FAIL idle_if%0d: t=%h p=%b want %h 0",
                         i, t, p, exp[i]);
            end
        end
    endtask

    task automatic test_frame_repend();
        logic v, p;
        logic [7:0] t;
        do_reset();
        level = 5'd16;
        pulse_frame();
        repeat (5) do_slot(1'b0, v, t, p);
        pulse_frame();
        for (int i = 1; i <= 9; i++) begin
            do_slot(1'b0, v, t, p);
            if (i == 8 || i == 9) begin
                checks++;
                if (t !== (i == 9 ? 8'h82 : 8'h02)) begin
                    errors++;
                    $display("FAIL repend_slot%0d: t=%h want %h",
                             i, t, i == 9 ? 8'h82 : 8'h02);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp[0] = 8'h01;
        exp[1] = 8'h82;
        exp[2] = 8'h84;
        exp[3] = 8'h83;
        do_reset();
        level = 5'd0;
        pulse_frame();
        toggle_wrap();
        @(negedge clk_pixel);
        bus.packet_slot = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_pixel);
            if (i == 3) bus.packet_slot = 1'b0;
            checks++;
            if (bus.packet_valid !== 1'b1 || bus.packet_type !== exp[i]) begin
                errors++;
                $display("FAIL b2b_%0d: v=%b t=%h want 1 %h",
                         i, bus.packet_valid, bus.packet_type, exp[i]);
            end
        end
        @(negedge clk_pixel);
        checks++;
        if (bus.packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: v=%b want 0", bus.packet_valid);
        end
    endtask

    task automatic test_same_cycle_acr();
        logic v, p;
        logic [7:0] t;
        do_reset();
        level = 5'd0;
        toggle_wrap();
        do_slot(1'b1, v, t, p);
        checks++;
        if (t !== 8'h01 || acr_overrun !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_acr: t=%h ov=%b want 01 0",
                     t, acr_overrun);
        end
        do_slot(1'b0, v, t, p);
        checks++;
        if (t !== 8'h01 || acr_overrun !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_refill: t=%h ov=%b want 01 0",
                     t, acr_overrun);
        end
        do_slot(1'b1, v, t, p);
        checks++;
        if (t !== 8'h01) begin
            errors++;
            $display("FAIL slot_event_acr: t=%h want 01", t);
        end
        do_slot(1'b0, v, t, p);
        checks++;
        if (t !== 8'h00) begin
            errors++;
            $display("FAIL slot_event_consumed: t=%h want 00", t);
        end
    endtask

    task automatic test_mid_reset();
        logic v, p;
        logic [7:0] t;
        level = 5'd0;
        pulse_frame();
        toggle_wrap();
        toggle_wrap();
        do_reset();
        checks++;
        if (acr_overrun !== 1'b0 || bus.packet_type !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_out: ov=%b t=%h want 0 00",
                     acr_overrun, bus.packet_type);
        end
        do_slot(1'b0, v, t, p);
        checks++;
        if (v !== 1'b1 || t !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_slot: v=%b t=%h want 1 00", v, t);
        end
    endtask

    initial begin
        bus.packet_slot = 1'b0;
        test_reset();
        test_acr_audio();
        test_audio_threshold();
        test_overrun();
        test_infoframe_promotion();
        test_infoframe_idle();
        test_frame_repend();
        test_back_to_back();
        test_same_cycle_acr();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
